// File: rtl/bus_sched_pkg.sv
// bus_sched_pkg: shared types and constants for the round-robin bus scheduler.
package bus_sched_pkg;
  localparam int ID_W = 8;
  localparam logic [ID_W-1:0] BROADCAST_ID = 8'hFF;
  typedef enum logic [1:0] {IDLE, GRANT, DELIVER} sched_state_t;
  typedef enum logic [1:0] {UNICAST, BCAST, DROP} dst_class_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request strictly after last.
module rr_arbiter #(
  parameter int N = 5,
  localparam int LW = N > 1 ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [LW-1:0] last,
  output logic [LW-1:0] gnt_idx,
  output logic          any
);
  logic [2*N-1:0] dbl;
  logic [2*N-1:0] masked;
  always_comb begin
    dbl = {req, req};
    masked = '0;
    gnt_idx = '0;
    for (int j = 0; j < 2*N; j++)
      masked[j] = dbl[j] && (j > int'(last)) && (j <= int'(last) + N);
    // scan downward so the lowest masked position wins
    for (int j = 2*N-1; j >= 0; j--)
      if (masked[j]) gnt_idx = LW'(j >= N ? j - N : j);
  end
  assign any = |req;
endmodule

// File: rtl/bus_rr_sched.sv
// bus_rr_sched: round-robin packet mover from source FIFOs to addressed or broadcast receive FIFOs.
module bus_rr_sched
  import bus_sched_pkg::*;
#(
  parameter int drvrs = 5,
  parameter int pckg_sz = 32,
  parameter logic [ID_W-1:0] broadcast = BROADCAST_ID
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [drvrs-1:0]                pndng,
  input  logic [drvrs-1:0][pckg_sz-1:0]   D_pop,
  output logic [drvrs-1:0]                pop,
  input  logic [drvrs-1:0]                full,
  output logic [drvrs-1:0]                push,
  output logic [drvrs-1:0][pckg_sz-1:0]   D_push,
  output logic                            busy,
  output logic [31:0]                     pkt_cnt,
  output logic [15:0]                     drop_cnt
);
  localparam int GW = drvrs > 1 ? $clog2(drvrs) : 1;
  sched_state_t state_q, state_d;
  logic [GW-1:0] gnt_q, gnt_d, last_q, last_d, arb_idx;
  logic [pckg_sz-1:0] pkt_q, pkt_d;
  logic [drvrs-1:0] mask_q, mask_d, pop_q, pop_d, push_q, push_d, new_mask;
  logic [31:0] pkt_cnt_q, pkt_cnt_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;
  logic [ID_W-1:0] dst;
  logic arb_any;
  dst_class_t cls;

  rr_arbiter #(.N(drvrs)) u_arb (
    .req(pndng), .last(last_q), .gnt_idx(arb_idx), .any(arb_any)
  );

  always_comb begin
    dst = D_pop[gnt_q][pckg_sz-1 -: ID_W];
    // a broadcast with nobody else on the bus has no target and is dropped
    cls = (int'(dst) < drvrs && dst != ID_W'(gnt_q)) ? UNICAST :
          (dst == broadcast && ~(drvrs'(1) << gnt_q) != '0) ? BCAST : DROP;
    new_mask = cls == UNICAST ? drvrs'(1) << dst :
               cls == BCAST   ? ~(drvrs'(1) << gnt_q) : '0;
    state_d = state_q;
    gnt_d = gnt_q;
    last_d = last_q;
    pkt_d = pkt_q;
    mask_d = mask_q;
    pop_d = '0;
    push_d = '0;
    pkt_cnt_d = pkt_cnt_q;
    drop_cnt_d = drop_cnt_q;
    case (state_q)
      IDLE: if (arb_any) begin
        state_d = GRANT;
        gnt_d = arb_idx;
        last_d = arb_idx;
        pop_d = drvrs'(1) << arb_idx;
      end
      GRANT: begin
        pkt_d = D_pop[gnt_q];
        mask_d = new_mask;
        if (cls == DROP) begin
          state_d = IDLE;
          drop_cnt_d = drop_cnt_q == 16'hFFFF ? drop_cnt_q : drop_cnt_q + 16'd1;
        end else begin
          state_d = DELIVER;
          if ((full & new_mask) == '0) begin
            push_d = new_mask;
            pkt_cnt_d = pkt_cnt_q + 32'd1;
          end
        end
      end
      DELIVER: if (push_q != '0) state_d = IDLE;
        else if ((full & mask_q) == '0) begin
          push_d = mask_q;
          pkt_cnt_d = pkt_cnt_q + 32'd1;
        end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      gnt_q <= '0;
      last_q <= GW'(drvrs - 1);
      pkt_q <= '0;
      mask_q <= '0;
      pop_q <= '0;
      push_q <= '0;
      pkt_cnt_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q <= gnt_d;
      last_q <= last_d;
      pkt_q <= pkt_d;
      mask_q <= mask_d;
      pop_q <= pop_d;
      push_q <= push_d;
      pkt_cnt_q <= pkt_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign pop = pop_q;
  assign push = push_q;
  assign D_push = {drvrs{pkt_q}};
  assign busy = state_q != IDLE;
  assign pkt_cnt = pkt_cnt_q;
  assign drop_cnt = drop_cnt_q;
endmodule

// File: tb/tb_bus_rr_sched.sv
// tb_bus_rr_sched: directed and randomized transfers checked against a transaction-level model.
module tb_bus_rr_sched;
  localparam int N = 5;
  localparam int W = 32;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [N-1:0] pndng = '0, full = '0, pop, push;
  logic [N-1:0][W-1:0] D_pop = '0, D_push;
  logic busy;
  logic [31:0] pkt_cnt;
  logic [15:0] drop_cnt;
  int total = 0, bad = 0;
  int m_last = N - 1, m_pkt = 0, m_drop = 0;

  always #5 clk = ~clk;

  bus_rr_sched dut (
    .clk(clk), .reset(reset), .pndng(pndng), .D_pop(D_pop), .pop(pop),
    .full(full), .push(push), .D_push(D_push), .busy(busy),
    .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int winner(input logic [N-1:0] p);
    for (int k = 1; k <= N; k++)
      if (p[(m_last + k) % N]) return (m_last + k) % N;
    return 0;
  endfunction

  // starts from an idle DUT at a falling edge and returns with it idle again
  task automatic xfer(input logic [N-1:0] pnd, input logic [W-1:0] word,
                      input logic [N-1:0] fl, input int hold);
    int w;
    logic [7:0] dst;
    logic [N-1:0] mask;
    w = winner(pnd);
    for (int i = 0; i < N; i++) D_pop[i] = $urandom;
    D_pop[w] = word;
    pndng = pnd;
    full = fl;
    dst = word[W-1 -: 8];
    mask = (int'(dst) < N && int'(dst) != w) ? N'(1) << dst :
           dst == 8'hFF ? ~(N'(1) << w) : '0;
    @(negedge clk);
    chk("pop", 64'(pop), 64'(N'(1) << w));
    chk("busy_grant", 64'(busy), 64'd1);
    m_last = w;
    pndng = N'($urandom);
    @(negedge clk);
    chk("pop_once", 64'(pop), 64'd0);
    pndng = '0;
    if (mask == '0) begin
      m_drop++;
      chk("drop_push", 64'(push), 64'd0);
      chk("drop_idle", 64'(busy), 64'd0);
      @(negedge clk);
    end else begin
      if ((fl & mask) != '0)
        for (int c = 0; c < hold; c++) begin
          chk("stall_push", 64'(push), 64'd0);
          chk("stall_busy", 64'(busy), 64'd1);
          if (c == hold - 1) full = '0;
          @(negedge clk);
        end
      chk("push", 64'(push), 64'(mask));
      for (int i = 0; i < N; i++) chk("d_push", 64'(D_push[i]), 64'(word));
      m_pkt++;
      @(negedge clk);
      chk("push_once", 64'(push), 64'd0);
      chk("idle", 64'(busy), 64'd0);
    end
    chk("pkt_cnt", 64'(pkt_cnt), 64'(m_pkt));
    chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
  endtask

  initial begin
    int pops[$];
    int cyc[$];
    int w;
    logic [7:0] d;
    repeat (2) @(negedge clk);
    chk("rst_pop", 64'(pop), 64'd0);
    chk("rst_push", 64'(push), 64'd0);
    chk("rst_dpush", 64'(|D_push), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_pkt", 64'(pkt_cnt), 64'd0);
    chk("rst_drop", 64'(drop_cnt), 64'd0);
    reset = 1'b1;
    @(negedge clk);

    // all sources pending back to back: strict rotation at one packet per 3 cycles
    for (int i = 0; i < N; i++) D_pop[i] = {8'((i + 1) % N), 24'($urandom)};
    pndng = '1;
    for (int c = 0; c < 40 && pops.size() < 6; c++) begin
      @(negedge clk);
      if (pop != '0) begin
        pops.push_back($clog2(pop));
        cyc.push_back(c);
      end
    end
    pndng = '0;
    chk("fair_count", 64'(pops.size()), 64'd6);
    for (int k = 0; k < 6 && k < pops.size(); k++) begin
      w = winner('1);
      chk("fair_order", 64'(pops[k]), 64'(w));
      m_last = w;
      if (k > 0) chk("fair_gap", 64'(cyc[k] - cyc[k-1]), 64'd3);
    end
    m_pkt += pops.size();
    repeat (4) @(negedge clk);
    chk("fair_idle", 64'(busy), 64'd0);
    chk("fair_pkt", 64'(pkt_cnt), 64'(m_pkt));

    xfer(5'b00010, 32'h0300ABCD, '0, 1);
    xfer(5'b00100, {8'hFF, 24'h123456}, '0, 1);
    xfer(5'b00001, {8'h04, 24'h00BEEF}, 5'b10000, 10);
    xfer(5'b01000, {8'h07, 24'h000001}, '0, 1);
    xfer(5'b00001, {8'h00, 24'h000002}, '0, 1);

    for (int t = 0; t < 40; t++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: d = 8'($urandom_range(0, N - 1));
        5, 6: d = 8'hFF;
        default: d = 8'($urandom_range(N, 254));
      endcase
      xfer(N'($urandom_range(1, (1 << N) - 1)), {d, 24'($urandom)},
           $urandom_range(0, 2) == 0 ? N'($urandom) : '0, $urandom_range(1, 4));
    end

    // abort a transfer stalled in delivery
    w = winner(5'b00001);
    D_pop[w] = {8'((w + 2) % N), 24'hDEAD00};
    pndng = 5'b00001;
    full = '1;
    repeat (3) @(negedge clk);
    chk("pre_rst_busy", 64'(busy), 64'd1);
    #2 reset = 1'b0;
    #1;
    chk("arst_pop", 64'(pop), 64'd0);
    chk("arst_push", 64'(push), 64'd0);
    chk("arst_dpush", 64'(|D_push), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_pkt", 64'(pkt_cnt), 64'd0);
    chk("arst_drop", 64'(drop_cnt), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    full = '0;
    pndng = '0;
    m_last = N - 1;
    m_pkt = 0;
    m_drop = 0;
    @(negedge clk);
    xfer(5'b10001, {8'h02, 24'h0F0F0F}, '0, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
